// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width, link register and
// destination-select encodings used by decode and the write-back path.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int LINK_REG   = 31;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_RSVD = 2'b11
  } reg_dst_mode_t;

endpackage

// File: rtl/dest_reg_pipeline_if.sv
// Bus between decode/hazard logic and the destination-register pipeline.
// master = decode side (drives instruction and control), slave = pipeline.
interface dest_reg_pipeline_if
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int STAGES     = 3
);

  logic                  in_valid;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [1:0]            reg_dst_mode;
  logic                  reg_write_in;
  logic                  stall;
  logic                  flush;
  logic [REG_ADDR_W-1:0] src_a;
  logic [REG_ADDR_W-1:0] src_b;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  wb_write;
  logic [STAGES-1:0]     hazard_a;
  logic [STAGES-1:0]     hazard_b;
  logic                  err_reserved;

  modport master (
    output in_valid, rt_addr, rd_addr, reg_dst_mode, reg_write_in,
           stall, flush, src_a, src_b,
    input  wb_dest, wb_write, hazard_a, hazard_b, err_reserved
  );

  modport slave (
    input  in_valid, rt_addr, rd_addr, reg_dst_mode, reg_write_in,
           stall, flush, src_a, src_b,
    output wb_dest, wb_write, hazard_a, hazard_b, err_reserved
  );

endinterface

// File: rtl/dest_reg_stage.sv
// One pipeline register holding (valid, write, dest).
// kill clears valid/write (dest is left as-is), load captures d_*, else hold.
module dest_reg_stage #(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  kill,
  input  logic                  d_valid,
  input  logic                  d_write,
  input  logic [REG_ADDR_W-1:0] d_dest,
  output logic                  q_valid,
  output logic                  q_write,
  output logic [REG_ADDR_W-1:0] q_dest
);

  logic                  valid_reg;
  logic                  write_reg;
  logic [REG_ADDR_W-1:0] dest_reg;

  // Reset beats kill, kill beats load; otherwise the entry holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      write_reg <= 1'b0;
      dest_reg  <= '0;
    end else if (kill) begin
      valid_reg <= 1'b0;
      write_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= d_valid;
      write_reg <= d_write;
      dest_reg  <= d_dest;
    end
  end

  assign q_valid = valid_reg;
  assign q_write = write_reg;
  assign q_dest  = dest_reg;

endmodule

// File: rtl/dest_reg_pipeline.sv
// Destination-register select plus a STAGES-deep carry pipeline that feeds
// the register-file write port and per-stage source-match hazard vectors.
module dest_reg_pipeline
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int STAGES     = 3,
  parameter int LINK_REG   = cpu_pkg::LINK_REG
) (
  input logic               clk,
  input logic               reset,
  dest_reg_pipeline_if.slave bus
);

  localparam logic [REG_ADDR_W-1:0] LINK_ADDR = REG_ADDR_W'(LINK_REG);

  logic                  accept;
  logic [REG_ADDR_W-1:0] sel_dest;
  logic                  sel_write;
  logic                  err_reg;

  logic [STAGES-1:0]     load_en;
  logic [STAGES-1:0]     kill_en;
  logic [STAGES-1:0]     d_valid;
  logic [STAGES-1:0]     d_write;
  logic [REG_ADDR_W-1:0] d_dest [STAGES];
  logic [STAGES-1:0]     st_valid;
  logic [STAGES-1:0]     st_write;
  logic [REG_ADDR_W-1:0] st_dest [STAGES];

  // Input only enters the pipe on a cycle that neither stalls nor flushes.
  assign accept = !bus.stall && !bus.flush;

  // Destination select; reserved mode falls back to rt and never writes,
  // and writes to register 0 are squashed here so they never surface later.
  always_comb begin
    sel_dest  = bus.rt_addr;
    sel_write = 1'b0;
    case (bus.reg_dst_mode)
      DST_RT:   sel_dest = bus.rt_addr;
      DST_RD:   sel_dest = bus.rd_addr;
      DST_LINK: sel_dest = LINK_ADDR;
      default:  sel_dest = bus.rt_addr;
    endcase
    sel_write = bus.in_valid && bus.reg_write_in &&
                (bus.reg_dst_mode != DST_RSVD) && (sel_dest != '0);
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign d_valid[gi] = bus.in_valid;
      assign d_write[gi] = sel_write;
      assign d_dest[gi]  = sel_dest;
      assign load_en[gi] = accept;
      assign kill_en[gi] = bus.flush;
    end else if (gi == STAGES - 1) begin : g_last
      // The oldest in-flight instruction still commits on a flush.
      assign d_valid[gi] = st_valid[gi-1];
      assign d_write[gi] = st_write[gi-1];
      assign d_dest[gi]  = st_dest[gi-1];
      assign load_en[gi] = !bus.stall || bus.flush;
      assign kill_en[gi] = 1'b0;
    end else begin : g_mid
      assign d_valid[gi] = st_valid[gi-1];
      assign d_write[gi] = st_write[gi-1];
      assign d_dest[gi]  = st_dest[gi-1];
      assign load_en[gi] = !bus.stall;
      assign kill_en[gi] = bus.flush;
    end

    dest_reg_stage #(.REG_ADDR_W(REG_ADDR_W)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .load    (load_en[gi]),
      .kill    (kill_en[gi]),
      .d_valid (d_valid[gi]),
      .d_write (d_write[gi]),
      .d_dest  (d_dest[gi]),
      .q_valid (st_valid[gi]),
      .q_write (st_write[gi]),
      .q_dest  (st_dest[gi])
    );

    // Register 0 is never a real dependency, so a zero source never matches.
    assign bus.hazard_a[gi] = st_valid[gi] && st_write[gi] &&
                              (st_dest[gi] == bus.src_a) && (bus.src_a != '0);
    assign bus.hazard_b[gi] = st_valid[gi] && st_write[gi] &&
                              (st_dest[gi] == bus.src_b) && (bus.src_b != '0);
  end

  // Sticky flag for a reserved destination mode on an accepted instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (accept && bus.in_valid && (bus.reg_dst_mode == DST_RSVD)) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.wb_dest      = st_dest[STAGES-1];
  assign bus.wb_write     = st_valid[STAGES-1] && st_write[STAGES-1];
  assign bus.err_reserved = err_reg;

endmodule

// File: tb/tb_dest_reg_pipeline.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared against a list-of-entries reference model of the pipe.
module tb_dest_reg_pipeline;

  localparam int S  = 3;
  localparam int AW = 5;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  typedef struct {
    bit v;
    bit w;
    int d;
  } ent_t;

  ent_t m[S];
  bit   m_err;

  dest_reg_pipeline_if #(.REG_ADDR_W(AW), .STAGES(S)) bus ();

  dest_reg_pipeline #(.REG_ADDR_W(AW), .STAGES(S), .LINK_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int mode, input int rt, input int rd, input bit wr);
    bus.in_valid     = v;
    bus.reg_dst_mode = 2'(mode);
    bus.rt_addr      = AW'(rt);
    bus.rd_addr      = AW'(rd);
    bus.reg_write_in = wr;
  endtask

  // Advance one clock, update the model with the inputs seen at that edge,
  // then compare every output against the model.
  task automatic step();
    int sel;
    bit wr;
    logic [S-1:0] ha;
    logic [S-1:0] hb;
    int mode;
    @(posedge clk);
    mode = int'(bus.reg_dst_mode);
    if (mode == 1)      sel = int'(bus.rd_addr);
    else if (mode == 2) sel = 31;
    else                sel = int'(bus.rt_addr);
    wr = bus.in_valid && bus.reg_write_in && (mode != 3) && (sel != 0);
    if (!reset) begin
      for (int i = 0; i < S; i++) m[i] = '{0, 0, 0};
      m_err = 0;
    end else if (bus.flush) begin
      m[S-1] = m[S-2];
      for (int i = 0; i < S - 1; i++) begin
        m[i].v = 0;
        m[i].w = 0;
      end
    end else if (!bus.stall) begin
      for (int i = S - 1; i > 0; i--) m[i] = m[i-1];
      m[0] = '{bus.in_valid, wr, sel};
      if (bus.in_valid && mode == 3) m_err = 1;
    end
    #1;
    for (int i = 0; i < S; i++) begin
      ha[i] = m[i].v && m[i].w && (m[i].d == int'(bus.src_a)) && (bus.src_a != 0);
      hb[i] = m[i].v && m[i].w && (m[i].d == int'(bus.src_b)) && (bus.src_b != 0);
    end
    check("wb_write", 32'(bus.wb_write), 32'(m[S-1].v && m[S-1].w));
    check("wb_dest", 32'(bus.wb_dest), 32'(m[S-1].d));
    check("hazard_a", 32'(bus.hazard_a), 32'(ha));
    check("hazard_b", 32'(bus.hazard_b), 32'(hb));
    check("err_reserved", 32'(bus.err_reserved), 32'(m_err));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_err    = 0;
    for (int i = 0; i < S; i++) m[i] = '{0, 0, 0};
    bus.stall = 0;
    bus.flush = 0;
    bus.src_a = 0;
    bus.src_b = 0;

    // Reset held 2 cycles with a live instruction presented.
    reset = 0;
    drive(1, 1, 0, 7, 1);
    step();
    step();
    check("rst_wb_write", 32'(bus.wb_write), 32'd0);
    check("rst_wb_dest", 32'(bus.wb_dest), 32'd0);
    check("rst_hazard_a", 32'(bus.hazard_a), 32'd0);
    check("rst_err", 32'(bus.err_reserved), 32'd0);
    reset = 1;

    // Mode sweep: rt, rd, link on consecutive cycles.
    drive(1, 0, 4, 9, 1); step();
    drive(1, 1, 4, 9, 1); step();
    drive(1, 2, 4, 9, 1); step();
    check("sweep_rt_dest", 32'(bus.wb_dest), 32'd4);
    check("sweep_rt_write", 32'(bus.wb_write), 32'd1);
    drive(0, 0, 0, 0, 0); step();
    check("sweep_rd_dest", 32'(bus.wb_dest), 32'd9);
    step();
    check("sweep_link_dest", 32'(bus.wb_dest), 32'd31);
    check("sweep_link_write", 32'(bus.wb_write), 32'd1);

    // Write to r0 is squashed; then reserved mode raises the sticky flag.
    drive(1, 1, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0); step(); step();
    check("r0_wb_write", 32'(bus.wb_write), 32'd0);
    drive(1, 3, 5, 0, 1); step();
    check("rsvd_err", 32'(bus.err_reserved), 32'd1);
    drive(0, 0, 0, 0, 0); step(); step();
    check("rsvd_wb_write", 32'(bus.wb_write), 32'd0);
    check("rsvd_err_sticky", 32'(bus.err_reserved), 32'd1);

    // Hazard walking through the stages.
    bus.src_a = 12;
    drive(1, 1, 0, 12, 1); step();
    check("haz_s0", 32'(bus.hazard_a), 32'b001);
    drive(0, 0, 0, 0, 0); step();
    check("haz_s1", 32'(bus.hazard_a), 32'b010);
    step();
    check("haz_s2", 32'(bus.hazard_a), 32'b100);
    step();
    check("haz_none", 32'(bus.hazard_a), 32'b000);
    bus.src_a = 0;
    drive(1, 0, 0, 0, 1); step();
    check("haz_zero", 32'(bus.hazard_a), 32'b000);

    // Stall with 8 in stage 1 and 3 in stage 0 while 15 waits at the input.
    bus.src_a = 3;
    bus.src_b = 8;
    drive(1, 1, 0, 8, 1); step();
    drive(1, 1, 0, 3, 1); step();
    drive(1, 1, 0, 15, 1);
    bus.stall = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("stall_haz_a", 32'(bus.hazard_a), 32'b001);
      check("stall_haz_b", 32'(bus.hazard_b), 32'b010);
    end
    bus.stall = 0;
    bus.src_a = 15;
    step();
    check("stall_release", 32'(bus.hazard_a), 32'b001);

    // Flush together with stall: oldest commits, younger ones die.
    drive(1, 1, 0, 10, 1); step();
    drive(1, 1, 0, 6, 1);  step();
    drive(1, 1, 0, 2, 1);  step();
    bus.src_a = 2;
    bus.src_b = 20;
    drive(1, 1, 0, 20, 1);
    bus.flush = 1;
    bus.stall = 1;
    step();
    check("flush_wb_dest", 32'(bus.wb_dest), 32'd6);
    check("flush_wb_write", 32'(bus.wb_write), 32'd1);
    check("flush_haz_a", 32'(bus.hazard_a), 32'd0);
    check("flush_haz_b", 32'(bus.hazard_b), 32'd0);
    bus.flush = 0;
    bus.stall = 0;
    drive(0, 0, 0, 0, 0);
    step();
    check("flush_after", 32'(bus.wb_write), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      reset     = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      bus.stall = ($urandom_range(0, 99) < 20);
      bus.flush = ($urandom_range(0, 99) < 10);
      bus.src_a = AW'($urandom_range(0, 7));
      bus.src_b = AW'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dest_reg_pipeline.md
Name: dest_reg_pipeline

Overview:
Parametrised successor to the single-stage write-register select. Selects the destination register address (rt, rd or link register) per instruction and carries it with valid/write flags through a configurable number of pipeline stages. Gives the register file its write-back target and the hazard unit per-stage source-match vectors. Sits between decode and the register-file write port in the pipelined CPU.

Parameters:
REG_ADDR_W, 5, register address width
STAGES, 3, pipeline depth from decode output to write-back (min 2)
LINK_REG, 31, destination selected in link mode (JAL)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  instruction presented this cycle
rt_addr  in  REG_ADDR_W  rt field
rd_addr  in  REG_ADDR_W  rd field
reg_dst_mode  in  2  00=rt, 01=rd, 10=LINK_REG, 11=reserved
reg_write_in  in  1  instruction writes a register
stall  in  1  freeze whole pipe
flush  in  1  kill all non-write-back stages
src_a  in  REG_ADDR_W  decode source A (rs)
src_b  in  REG_ADDR_W  decode source B (rt)
wb_dest  out  REG_ADDR_W  write-back destination (last stage)
wb_write  out  1  write-back enable (last stage valid & write)
hazard_a  out  STAGES  bit i: stage i will write src_a
hazard_b  out  STAGES  bit i: stage i will write src_b
err_reserved  out  1  sticky: reserved mode seen on valid input

Behaviour:
- Reset: clk edge with reset=0 clears every stage's valid, write and dest to 0, and clears err_reserved. Outputs read 0 next cycle. Reset overrides stall and flush, including mid-operation.
- Selection (combinational, captured into stage 0):
  - mode 00 gives rt_addr; 01 gives rd_addr; 10 gives LINK_REG.
  - mode 11 gives rt_addr with write forced 0.
- Write qualification: stage-0 write = in_valid & reg_write_in & (mode != 11) & (selected dest != 0). Writes to register 0 are squashed at entry, so they never reach wb_write or hazard vectors.
- Advance, when stall=0 and flush=0: stage0 <= new entry (valid=in_valid); stage i <= stage i-1 for i = 1..STAGES-1.
- Latency: input accepted at edge n appears at stage 0 after edge n and at wb_dest/wb_write after edge n+STAGES-1. This gives STAGES cycles of occupancy.
- Stall=1, flush=0: all stages hold and the input is not accepted. Upstream keeps it presented.
- Flush=1:
  - Stages 0..STAGES-2 get valid=0 and write=0.
  - The last stage loads stage STAGES-2's pre-flush contents, so the oldest instruction still commits.
  - The input is dropped.
  - Flush wins over stall.
- Hazard vectors: hazard_a[i] = valid_i & write_i & (dest_i == src_a) & (src_a != 0); hazard_b likewise. Purely combinational from registered state and current src_a/src_b. Same-cycle input is not included.
- wb_write = valid & write of the last stage. wb_dest is held even when wb_write=0 (don't-care for the register file).
- err_reserved: set on any accepted cycle (not stalled, not flushed) with in_valid=1 and mode=11. Cleared only by reset.
- Back-to-back instructions with the same destination are kept as independent entries. Multiple hazard bits may be set; priority resolution (youngest wins) belongs to the forwarding unit.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADDR_W
  - LINK_REG
  - reg_dst_mode encodings: DST_RT, DST_RD, DST_LINK, DST_RSVD
- Natural sub-module: dest_reg_stage, one pipeline register (valid, write, dest) with load/hold/kill controls. The top generates STAGES instances plus the selection and compare logic.

Test Plan:
- Reset: drive reset=0 for 2 cycles with in_valid=1, mode=01, rd=7 -> wb_write=0, wb_dest=0, hazard_a=hazard_b=0, err_reserved=0.
- Mode sweep (STAGES=3): send rt=4/rd=9 with mode 00, then 01, then 10 in consecutive cycles, reg_write_in=1. Expect wb_dest 4, 9, 31 with wb_write=1 on the 3rd, 4th and 5th edges after the first input.
- Zero-register and reserved mode: mode=01, rd=0 -> wb_write=0 at write-back. Then mode=11, rt=5 -> wb_write=0 and err_reserved=1 from the next edge onward, staying 1.
- Hazard:
  - Inject dest=12 (mode 01) with src_a=12 held. Expect hazard_a=001, then 010, then 100 on successive cycles, then 000.
  - src_a=0 with a stage holding dest 0 -> hazard_a=000.
- Stall: with dest=3 in stage 0 and dest=8 in stage 1, hold stall=1 for 4 cycles while presenting rd=15 -> stage contents and hazard vectors unchanged. After release, 15 enters stage 0.
- Flush plus simultaneous stall: stages hold {A=2, B=6, C=10} (stage 0..2), assert flush=1 and stall=1 together -> after the edge wb_dest=6 with wb_write=1, stages 0 and 1 are invalid, and the input is dropped.
